csr_bank: RTL and testbench

- Parametrised multi-channel control/status register bank. It is the successor to the single fixed-width CSR used by the AES, SHA2, PRNG and DSA engines.
- Each channel owns one CSR with:
  - a self-clearing START bit that produces a registered start pulse,
  - a BUSY flag driven by a per-channel FSM,
  - sticky DONE and ERR flags, cleared by writing 1,
  - an interrupt enable,
  - free software control bits.
- A per-channel watchdog flags engines that never report completion.
- One merged interrupt line and a single muxed read port serve the host-facing top level.

---
 rtl/csr_pkg.sv | 20 ++
 rtl/csr_channel.sv | 107 ++++++++++
 rtl/csr_bank.sv | 70 +++++++
 tb/tb_csr_bank.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/csr_pkg.sv
// csr_pkg -- CSR bit positions and channel FSM state shared by csr_bank. Rev 1.0
`default_nettype none

package csr_pkg;

  localparam int CSR_START    = 0;
  localparam int CSR_BUSY     = 1;
  localparam int CSR_DONE     = 2;
  localparam int CSR_ERR      = 3;
  localparam int CSR_IE       = 4;
  localparam int CSR_CTRL_LSB = 5;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } ch_state_t;

endpackage

`default_nettype wire

// File: rtl/csr_channel.sv
// csr_channel -- one CSR with start pulse, IDLE/BUSY FSM, sticky flags and watchdog. Rev 1.0
`default_nettype none

module csr_channel
  import csr_pkg::*;
#(
  parameter int CSR_W = 8,
  parameter int TMO_W = 16
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    wr_en_i,
  input  logic [CSR_W-1:0]        wr_data_i,
  input  logic                    hw_done_i,
  input  logic                    hw_err_i,
  input  logic [TMO_W-1:0]        tmo_limit_i,
  output logic [CSR_W-1:0]        csr_o,
  output logic                    start_o,
  output logic                    busy_o,
  output logic [CSR_W-CSR_CTRL_LSB-1:0] ctrl_o,
  output logic                    flag_o
);

  localparam int CTRL_W = CSR_W - CSR_CTRL_LSB;

  ch_state_t          state_q, state_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic               ie_q, ie_d;
  logic               start_q, start_d;
  logic [CTRL_W-1:0]  ctrl_q, ctrl_d;
  logic [TMO_W-1:0]   cnt_q, cnt_d;
  logic               tmo_hit;

  assign tmo_hit = (tmo_limit_i != '0) && (cnt_q == tmo_limit_i - TMO_W'(1));

  always_comb begin
    state_d = state_q;
    done_d  = done_q;
    err_d   = err_q;
    ie_d    = ie_q;
    ctrl_d  = ctrl_q;
    cnt_d   = cnt_q;
    start_d = 1'b0;

    if (wr_en_i) begin
      ie_d   = wr_data_i[CSR_IE];
      ctrl_d = wr_data_i[CSR_CTRL_LSB +: CTRL_W];
      if (wr_data_i[CSR_DONE]) done_d = 1'b0;
      if (wr_data_i[CSR_ERR])  err_d  = 1'b0;
    end

    // Hardware events are applied after the host write so a same-cycle set wins over W1C.
    case (state_q)
      IDLE: begin
        if (wr_en_i && wr_data_i[CSR_START]) begin
          state_d = BUSY;
          done_d  = 1'b0;
          err_d   = 1'b0;
          cnt_d   = '0;
          start_d = 1'b1;
        end
      end
      BUSY: begin
        if (hw_done_i) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else if (hw_err_i || tmo_hit) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + TMO_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      ie_q    <= 1'b0;
      ctrl_q  <= '0;
      cnt_q   <= '0;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      err_q   <= err_d;
      ie_q    <= ie_d;
      ctrl_q  <= ctrl_d;
      cnt_q   <= cnt_d;
      start_q <= start_d;
    end
  end

  assign busy_o  = (state_q == BUSY);
  assign start_o = start_q;
  assign ctrl_o  = ctrl_q;
  assign flag_o  = ie_q & (done_q | err_q);
  assign csr_o   = {ctrl_q, ie_q, err_q, done_q, busy_o, 1'b0};

endmodule

`default_nettype wire

// File: rtl/csr_bank.sv
// csr_bank -- NUM_CH independent CSR channels with a muxed read port and merged irq. Rev 1.0
`default_nettype none

module csr_bank
  import csr_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CSR_W  = 8,
  parameter int TMO_W  = 16
) (
  input  logic                                  clock,
  input  logic                                  reset_n,
  input  logic [NUM_CH-1:0]                     wr_en,
  input  logic [CSR_W-1:0]                      wr_data,
  input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] rd_sel,
  output logic [CSR_W-1:0]                      rd_data,
  input  logic [NUM_CH-1:0]                     hw_done,
  input  logic [NUM_CH-1:0]                     hw_err,
  input  logic [TMO_W-1:0]                      tmo_limit,
  output logic [NUM_CH-1:0]                     start_o,
  output logic [NUM_CH-1:0]                     busy_o,
  output logic [NUM_CH*(CSR_W-CSR_CTRL_LSB)-1:0] ctrl_o,
  output logic                                  irq
);

  localparam int SEL_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int CTRL_W = CSR_W - CSR_CTRL_LSB;

  logic [NUM_CH-1:0][CSR_W-1:0] csr_all;
  logic [NUM_CH-1:0]            flag;
  logic                         irq_q;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    csr_channel #(
      .CSR_W (CSR_W),
      .TMO_W (TMO_W)
    ) u_ch (
      .clock       (clock),
      .reset_n     (reset_n),
      .wr_en_i     (wr_en[g]),
      .wr_data_i   (wr_data),
      .hw_done_i   (hw_done[g]),
      .hw_err_i    (hw_err[g]),
      .tmo_limit_i (tmo_limit),
      .csr_o       (csr_all[g]),
      .start_o     (start_o[g]),
      .busy_o      (busy_o[g]),
      .ctrl_o      (ctrl_o[g*CTRL_W +: CTRL_W]),
      .flag_o      (flag[g])
    );
  end

  // Selects beyond the last channel fall through to the zero default.
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (rd_sel == SEL_W'(i)) rd_data = csr_all[i];
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) irq_q <= 1'b0;
    else          irq_q <= |flag;
  end

  assign irq = irq_q;

endmodule

`default_nettype wire

// File: tb/tb_csr_bank.sv
// tb_csr_bank -- scoreboard bench: stimulus schedules expected outputs, a monitor checks them. Rev 1.0
`default_nettype none

module tb_csr_bank;

  localparam int NUM_CH = 5;
  localparam int CSR_W  = 8;
  localparam int TMO_W  = 16;
  localparam int SEL_W  = 3;
  localparam int CTRL_W = CSR_W - 5;

  localparam int SIG_RD    = 0;
  localparam int SIG_START = 1;
  localparam int SIG_BUSY  = 2;
  localparam int SIG_IRQ   = 3;
  localparam int SIG_CTRL  = 4;

  logic                       clock;
  logic                       reset_n;
  logic [NUM_CH-1:0]          wr_en;
  logic [CSR_W-1:0]           wr_data;
  logic [SEL_W-1:0]           rd_sel;
  logic [CSR_W-1:0]           rd_data;
  logic [NUM_CH-1:0]          hw_done;
  logic [NUM_CH-1:0]          hw_err;
  logic [TMO_W-1:0]           tmo_limit;
  logic [NUM_CH-1:0]          start_o;
  logic [NUM_CH-1:0]          busy_o;
  logic [NUM_CH*CTRL_W-1:0]   ctrl_o;
  logic                       irq;

  csr_bank #(
    .NUM_CH (NUM_CH),
    .CSR_W  (CSR_W),
    .TMO_W  (TMO_W)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .rd_sel    (rd_sel),
    .rd_data   (rd_data),
    .hw_done   (hw_done),
    .hw_err    (hw_err),
    .tmo_limit (tmo_limit),
    .start_o   (start_o),
    .busy_o    (busy_o),
    .ctrl_o    (ctrl_o),
    .irq       (irq)
  );

  typedef struct {
    int          cyc;
    int          sig;
    logic [31:0] exp;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   cyc    = 0;
  int   n_vec  = 0;
  int   n_err  = 0;
  bit   done_f = 1'b0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic expect_at(input int dly, input int sig, input logic [31:0] exp, input string nm);
    exp_t e;
    e.cyc  = cyc + dly;
    e.sig  = sig;
    e.exp  = exp;
    e.name = nm;
    sb.push_back(e);
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Monitor: every falling edge, compare all entries scheduled for this cycle.
  initial begin
    logic [31:0] act;
    forever begin
      @(negedge clock);
      for (int k = sb.size() - 1; k >= 0; k--) begin
        if (sb[k].cyc == cyc) begin
          case (sb[k].sig)
            SIG_RD:    act = 32'(rd_data);
            SIG_START: act = 32'(start_o);
            SIG_BUSY:  act = 32'(busy_o);
            SIG_IRQ:   act = 32'(irq);
            default:   act = 32'(ctrl_o);
          endcase
          n_vec++;
          if (act !== sb[k].exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got 0x%0h, expected 0x%0h", sb[k].name, cyc, act, sb[k].exp);
          end
          sb.delete(k);
        end
      end
    end
  end

  initial begin
    #200000;
    if (!done_f) begin
      $display("FAIL timeout: bench did not complete, got running, expected finished");
      $fatal(1, "timeout");
    end
  end

  initial begin
    reset_n   = 1'b0;
    wr_en     = '0;
    wr_data   = '0;
    rd_sel    = '0;
    hw_done   = '0;
    hw_err    = '0;
    tmo_limit = '0;
    tick(3);
    reset_n = 1'b1;
    expect_at(0, SIG_RD, 32'h00, "reset_rd");
    expect_at(0, SIG_BUSY, 32'h00, "reset_busy");
    expect_at(0, SIG_IRQ, 32'h0, "reset_irq");
    tick(1);

    // Reset applied while ch0 is BUSY
    wr_en = 5'b00001; wr_data = 8'h01;
    expect_at(1, SIG_START, 32'h01, "rst_pre_start");
    expect_at(1, SIG_RD, 32'h02, "rst_pre_rd");
    expect_at(2, SIG_START, 32'h00, "rst_pre_start_end");
    tick(1); wr_en = '0;
    tick(2);
    reset_n = 1'b0;
    expect_at(0, SIG_BUSY, 32'h00, "rst_mid_busy");
    expect_at(0, SIG_RD, 32'h00, "rst_mid_rd");
    tick(2);
    reset_n = 1'b1;
    expect_at(0, SIG_RD, 32'h00, "rst_rel_rd");
    expect_at(0, SIG_IRQ, 32'h0, "rst_rel_irq");
    expect_at(1, SIG_START, 32'h00, "rst_rel_nostart1");
    expect_at(2, SIG_START, 32'h00, "rst_rel_nostart2");
    expect_at(2, SIG_BUSY, 32'h00, "rst_rel_busy");
    tick(3);

    // Normal run on ch1
    rd_sel = 3'd1; wr_en = 5'b00010; wr_data = 8'h31;
    expect_at(1, SIG_START, 32'h02, "n_start");
    expect_at(1, SIG_RD, 32'h32, "n_rd_busy");
    expect_at(1, SIG_CTRL, 32'h0008, "n_ctrl");
    expect_at(2, SIG_START, 32'h00, "n_start_end");
    tick(1); wr_en = '0;
    tick(1);
    hw_done = 5'b00010;
    expect_at(1, SIG_RD, 32'h34, "n_rd_done");
    expect_at(1, SIG_IRQ, 32'h0, "n_irq_lat");
    expect_at(2, SIG_IRQ, 32'h1, "n_irq_set");
    tick(1); hw_done = '0;
    tick(1);
    wr_en = 5'b00010; wr_data = 8'h34;
    expect_at(1, SIG_RD, 32'h30, "n_rd_clr");
    expect_at(2, SIG_IRQ, 32'h0, "n_irq_clr");
    tick(1); wr_en = '0;
    tick(2);

    // Watchdog on ch0
    rd_sel = 3'd0; tmo_limit = 16'd5; wr_en = 5'b00001; wr_data = 8'h01;
    expect_at(1, SIG_BUSY, 32'h01, "wd_busy1");
    expect_at(5, SIG_RD, 32'h02, "wd_rd5");
    expect_at(6, SIG_RD, 32'h08, "wd_rd_err");
    expect_at(6, SIG_BUSY, 32'h00, "wd_busy_off");
    expect_at(7, SIG_IRQ, 32'h0, "wd_irq_ie0");
    tick(1); wr_en = '0;
    tick(7);
    tmo_limit = 16'd0; wr_en = 5'b00001; wr_data = 8'h01;
    expect_at(1, SIG_RD, 32'h02, "wd0_rd");
    expect_at(1000, SIG_BUSY, 32'h01, "wd0_busy1000");
    tick(1); wr_en = '0;
    tick(1000);
    hw_done = 5'b00001;
    expect_at(1, SIG_RD, 32'h04, "wd0_done");
    tick(1); hw_done = '0;
    tick(1);

    // Collisions on ch2
    rd_sel = 3'd2; wr_en = 5'b00100; wr_data = 8'h11;
    tick(1); wr_en = '0;
    tick(1);
    hw_done = 5'b00100; wr_en = 5'b00100; wr_data = 8'h14;
    expect_at(1, SIG_RD, 32'h14, "col_w1c_done");
    expect_at(1, SIG_BUSY, 32'h00, "col_busy");
    expect_at(2, SIG_IRQ, 32'h1, "col_irq");
    tick(1); hw_done = '0; wr_en = '0;
    tick(1);
    wr_en = 5'b00100; wr_data = 8'h14;
    expect_at(1, SIG_RD, 32'h10, "col_clr");
    expect_at(2, SIG_IRQ, 32'h0, "col_irq_clr");
    tick(1); wr_en = '0;
    tick(2);
    wr_en = 5'b00100; wr_data = 8'h11;
    tick(1); wr_en = '0;
    tick(1);
    hw_done = 5'b00100; hw_err = 5'b00100;
    expect_at(1, SIG_RD, 32'h14, "col_done_err");
    tick(1); hw_done = '0; hw_err = '0;
    tick(1);
    wr_en = 5'b00100; wr_data = 8'h1C;
    expect_at(1, SIG_RD, 32'h10, "col_clr2");
    expect_at(2, SIG_IRQ, 32'h0, "col_irq_clr2");
    tick(1); wr_en = '0;
    tick(2);

    // Restart while BUSY on ch0: counter keeps running from the first start
    rd_sel = 3'd0; tmo_limit = 16'd8; wr_en = 5'b00001; wr_data = 8'h01;
    expect_at(1, SIG_START, 32'h01, "rs_start");
    expect_at(8, SIG_RD, 32'h02, "rs_rd8");
    expect_at(9, SIG_RD, 32'h08, "rs_tmo");
    tick(1); wr_en = '0;
    tick(2);
    wr_en = 5'b00001; wr_data = 8'h01;
    expect_at(1, SIG_START, 32'h00, "rs_nopulse");
    expect_at(1, SIG_BUSY, 32'h01, "rs_busy");
    tick(1); wr_en = '0;
    tick(7);
    tmo_limit = 16'd0; wr_en = 5'b00001; wr_data = 8'h01;
    expect_at(1, SIG_RD, 32'h02, "sd_rd");
    tick(1); wr_en = '0;
    tick(1);
    wr_en = 5'b00001; wr_data = 8'h01; hw_done = 5'b00001;
    expect_at(1, SIG_RD, 32'h04, "sd_done");
    expect_at(1, SIG_START, 32'h00, "sd_nopulse1");
    expect_at(2, SIG_START, 32'h00, "sd_nopulse2");
    expect_at(2, SIG_BUSY, 32'h00, "sd_idle");
    tick(1); wr_en = '0; hw_done = '0;
    tick(2);

    // Multi-channel: ch0 and ch3, completed in reverse order
    wr_en = 5'b00001; wr_data = 8'h11;
    expect_at(1, SIG_START, 32'h01, "mc_start0");
    tick(1);
    wr_en = 5'b01000; wr_data = 8'h11;
    expect_at(1, SIG_START, 32'h08, "mc_start3");
    expect_at(1, SIG_BUSY, 32'h09, "mc_busy");
    tick(1); wr_en = '0;
    tick(1);
    rd_sel = 3'd3; hw_done = 5'b01000;
    expect_at(1, SIG_RD, 32'h14, "mc_rd3");
    expect_at(1, SIG_BUSY, 32'h01, "mc_busy0");
    tick(1);
    hw_done = '0; hw_err = 5'b00001;
    expect_at(1, SIG_BUSY, 32'h00, "mc_busy_none");
    expect_at(2, SIG_IRQ, 32'h1, "mc_irq");
    tick(1);
    hw_err = '0; rd_sel = 3'd0;
    expect_at(0, SIG_RD, 32'h18, "mc_rd0");
    tick(1);
    wr_en = 5'b01000; wr_data = 8'h14;
    expect_at(2, SIG_IRQ, 32'h1, "mc_irq_hold");
    tick(1); wr_en = '0;
    tick(2);
    expect_at(0, SIG_IRQ, 32'h1, "mc_irq_hold2");
    wr_en = 5'b00001; wr_data = 8'h18;
    expect_at(1, SIG_RD, 32'h10, "mc_clr0");
    expect_at(2, SIG_IRQ, 32'h0, "mc_irq_clr");
    tick(1); wr_en = '0;
    tick(2);
    rd_sel = 3'd3;
    expect_at(0, SIG_RD, 32'h10, "mc_rd3_clr");
    tick(1);
    rd_sel = 3'd5;
    expect_at(0, SIG_RD, 32'h00, "sel_oob5");
    tick(1);
    rd_sel = 3'd7;
    expect_at(0, SIG_RD, 32'h00, "sel_oob7");
    tick(1);
    rd_sel = 3'd4;
    expect_at(0, SIG_RD, 32'h00, "sel_ch4");
    tick(3);

    foreach (sb[k]) begin
      n_vec++;
      n_err++;
      $display("FAIL %s: got unchecked, expected check at cyc %0d", sb[k].name, sb[k].cyc);
    end
    done_f = 1'b1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
